capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl_pkg.sv | 6 +
 rtl/capture_ctrl_axis_out_reg.sv | 42 ++++
 rtl/capture_ctrl.sv | 99 +++++++++
 tb/tb_capture_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/capture_ctrl_pkg.sv
// capture_ctrl_pkg: shared state encoding and default widths for the ADC capture controller
package capture_ctrl_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;
    typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, FLUSH} state_t;
endpackage

// File: rtl/capture_ctrl_axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream output register; free means a load this cycle is safe
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              tready,
    output logic              tvalid,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast,
    output logic              free
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_comb begin
        free    = !valid_q || tready;
        valid_d = load ? 1'b1 : (valid_q && tready) ? 1'b0 : valid_q;
        data_d  = load ? load_data : data_q;
        last_d  = load ? load_last : last_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign tvalid = valid_q;
    assign tdata  = data_q;
    assign tlast  = last_q;
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: gates ADC words into AXI-Stream packets framed by sync, with length limit and overflow tracking
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              sync,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_data_valid,
    input  logic [CNT_W-1:0]  max_packet_len,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [CNT_W-1:0]  packet_count,
    output logic              overflow,
    input  logic              overflow_clear,
    output logic              busy
);
    state_t            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [CNT_W-1:0]  max_len_q, max_len_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  packet_count_q, packet_count_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  lim;
    logic              trig, cap, drop, take, flush_out, hit, load, free;

    always_comb begin
        // the limit is taken straight from the port on the trigger cycle, before it is registered
        lim        = (state_q == WAIT_TRIG) ? max_packet_len : max_len_q;
        trig       = state_q == WAIT_TRIG && enable && sync;
        cap        = adc_data_valid && sync && (trig || state_q == CAPTURE);
        drop       = cap && pend_valid_q && !free;
        take       = cap && !drop;
        flush_out  = state_q == FLUSH && pend_valid_q && free;
        load       = (take && pend_valid_q) || flush_out;
        word_cnt_d = take ? (trig ? CNT_W'(1) : word_cnt_q + CNT_W'(1)) :
                     (state_q == CAPTURE) ? word_cnt_q : '0;
        hit        = lim != '0 && word_cnt_d == lim;
        pend_valid_d   = take ? 1'b1 : flush_out ? 1'b0 : pend_valid_q;
        pend_data_d    = take ? adc_data : pend_data_q;
        max_len_d      = trig ? max_packet_len : max_len_q;
        packet_count_d = (m_axis_tvalid && m_axis_tready && m_axis_tlast) ?
                         packet_count_q + CNT_W'(1) : packet_count_q;
        overflow_d     = drop || (overflow_q && !overflow_clear);
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = enable ? ARM : IDLE;
            ARM:       state_d = !enable ? IDLE : !sync ? WAIT_TRIG : ARM;
            WAIT_TRIG: state_d = !enable ? IDLE : sync ? (hit ? FLUSH : CAPTURE) : WAIT_TRIG;
            CAPTURE:   state_d = (!sync || !enable || hit) ? FLUSH : CAPTURE;
            FLUSH:     state_d = (pend_valid_q && !free) ? FLUSH : enable ? ARM : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            pend_valid_q   <= 1'b0;
            pend_data_q    <= '0;
            max_len_q      <= '0;
            word_cnt_q     <= '0;
            packet_count_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_valid_q   <= pend_valid_d;
            pend_data_q    <= pend_data_d;
            max_len_q      <= max_len_d;
            word_cnt_q     <= word_cnt_d;
            packet_count_q <= packet_count_d;
            overflow_q     <= overflow_d;
        end
    end

    axis_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .load_data(pend_data_q),
        .load_last(flush_out),
        .tready   (m_axis_tready),
        .tvalid   (m_axis_tvalid),
        .tdata    (m_axis_tdata),
        .tlast    (m_axis_tlast),
        .free     (free)
    );

    assign packet_count = packet_count_q;
    assign overflow     = overflow_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed per-cycle vector table plus a mid-packet reset sequence
module tb_capture_ctrl;
    logic        clk = 1'b0, resetn = 1'b0, enable = 1'b0, sync = 1'b0, adc_data_valid = 1'b0;
    logic        m_axis_tready = 1'b1, overflow_clear = 1'b0;
    logic [31:0] adc_data = '0, max_packet_len = '0;
    logic [31:0] m_axis_tdata, packet_count;
    logic        m_axis_tvalid, m_axis_tlast, overflow, busy;
    int          checks = 0, errors = 0;

    typedef struct {
        logic en, sy, vl; logic [31:0] d; logic rdy; logic [31:0] mx; logic clr;
        logic tv; logic [31:0] td; logic tl; logic [31:0] pc; logic ov, bz;
    } vec_t;
    vec_t vecs[$];

    capture_ctrl #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .sync(sync),
        .adc_data(adc_data), .adc_data_valid(adc_data_valid), .max_packet_len(max_packet_len),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .packet_count(packet_count), .overflow(overflow),
        .overflow_clear(overflow_clear), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic sy, logic vl, logic [31:0] d, logic rdy,
                                logic [31:0] mx, logic clr, logic tv, logic [31:0] td,
                                logic tl, logic [31:0] pc, logic ov, logic bz);
        vec_t v;
        v.en = en; v.sy = sy; v.vl = vl; v.d = d; v.rdy = rdy; v.mx = mx; v.clr = clr;
        v.tv = tv; v.td = td; v.tl = tl; v.pc = pc; v.ov = ov; v.bz = bz;
        return v;
    endfunction

    task automatic check(input string nm, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {tv,td,tl,pc,ov,bz}=%h expected %h", nm, got, exp);
        end
    endtask

    // tdata/tlast are only compared while a word is expected on the bus
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        enable = v.en; sync = v.sy; adc_data_valid = v.vl; adc_data = v.d;
        m_axis_tready = v.rdy; max_packet_len = v.mx; overflow_clear = v.clr;
        @(posedge clk);
        #1;
        check(nm, {m_axis_tvalid, v.tv ? m_axis_tdata : 32'h0, v.tv ? m_axis_tlast : 1'b0,
                   packet_count, overflow, busy},
                  {v.tv, v.tv ? v.td : 32'h0, v.tv & v.tl, v.pc, v.ov, v.bz});
    endtask

    initial begin
        // basic 5-word packet
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,0,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,1, 1,1,0,0, 0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,1, 2,1,0,0, 1, 1,0,0,0,1));
        vecs.push_back(mk(1,1,1, 3,1,0,0, 1, 2,0,0,0,1));
        vecs.push_back(mk(1,1,1, 4,1,0,0, 1, 3,0,0,0,1));
        vecs.push_back(mk(1,1,1, 5,1,0,0, 1, 4,0,0,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,0,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 1, 5,1,0,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,1,0,1));
        // max_packet_len=3 with sync held for 8 words
        vecs.push_back(mk(1,1,1,11,1,3,0, 0, 0,0,1,0,1));
        vecs.push_back(mk(1,1,1,12,1,0,0, 1,11,0,1,0,1));
        vecs.push_back(mk(1,1,1,13,1,0,0, 1,12,0,1,0,1));
        vecs.push_back(mk(1,1,1,14,1,0,0, 1,13,1,1,0,1));
        for (int i = 15; i <= 18; i++) vecs.push_back(mk(1,1,1,i,1,0,0, 0,0,0,2,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,2,0,1));
        // sync pulse with no valid data: empty packet
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,0,0,1,0,0, 0,0,0,2,0,1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,1,0,0, 0,0,0,2,0,1));
        // 10 cycles of backpressure
        vecs.push_back(mk(1,1,1,21,0,0,0, 0, 0,0,2,0,1));
        vecs.push_back(mk(1,1,1,22,0,0,0, 1,21,0,2,0,1));
        for (int i = 23; i <= 30; i++) vecs.push_back(mk(1,1,1,i,0,0,0, 1,21,0,2,1,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,2,1,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 1,22,1,2,1,1));
        vecs.push_back(mk(1,0,0, 0,1,0,1, 0, 0,0,3,0,1));
        // drop and clear in the same cycle: set wins
        vecs.push_back(mk(1,1,1,31,0,0,0, 0, 0,0,3,0,1));
        vecs.push_back(mk(1,1,1,32,0,0,0, 1,31,0,3,0,1));
        vecs.push_back(mk(1,1,1,33,0,0,1, 1,31,0,3,1,1));
        vecs.push_back(mk(1,0,0, 0,0,0,1, 1,31,0,3,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 1,32,1,3,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,4,0,1));
        // re-enable while sync is high: must wait for sync low then high
        vecs.push_back(mk(0,0,0, 0,1,0,0, 0, 0,0,4,0,0));
        vecs.push_back(mk(1,1,1,41,1,0,0, 0, 0,0,4,0,1));
        vecs.push_back(mk(1,1,1,42,1,0,0, 0, 0,0,4,0,1));
        vecs.push_back(mk(1,0,1,43,1,0,0, 0, 0,0,4,0,1));
        vecs.push_back(mk(1,1,1,44,1,0,0, 0, 0,0,4,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,4,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 1,44,1,4,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,5,0,1));
        // enable dropped during capture ends the packet and returns to IDLE
        vecs.push_back(mk(1,1,1,51,1,0,0, 0, 0,0,5,0,1));
        vecs.push_back(mk(0,1,1,52,1,0,0, 1,51,0,5,0,1));
        vecs.push_back(mk(0,1,0, 0,1,0,0, 1,52,1,5,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 0, 0,0,6,0,0));
        // max_packet_len=1: the trigger word alone forms the packet
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,6,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,6,0,1));
        vecs.push_back(mk(1,1,1,61,1,1,0, 0, 0,0,6,0,1));
        vecs.push_back(mk(1,1,1,62,1,0,0, 1,61,1,6,0,1));
        vecs.push_back(mk(1,1,1,63,1,0,0, 0, 0,0,7,0,1));
        vecs.push_back(mk(1,0,0, 0,1,0,0, 0, 0,0,7,0,1));

        #12;
        check("reset_state", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, packet_count, overflow, busy}, 68'h0);
        @(negedge clk);
        resetn = 1'b1;
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset with two words in flight
        apply(mk(1,1,1,71,1,0,0, 0, 0,0,7,0,1), "rst_w1");
        apply(mk(1,1,1,72,1,0,0, 1,71,0,7,0,1), "rst_w2");
        @(negedge clk);
        enable = 1'b0; sync = 1'b0; adc_data_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("async_reset", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, packet_count, overflow, busy}, 68'h0);
        @(negedge clk);
        resetn = 1'b1;
        apply(mk(1,0,0, 0,1,0,0, 0, 0,0,0,0,1), "post_arm");
        apply(mk(1,0,0, 0,1,0,0, 0, 0,0,0,0,1), "post_wait");
        apply(mk(1,1,1,81,1,0,0, 0, 0,0,0,0,1), "post_w1");
        apply(mk(1,1,1,82,1,0,0, 1,81,0,0,0,1), "post_w2");
        apply(mk(1,0,0, 0,1,0,0, 0, 0,0,0,0,1), "post_flush");
        apply(mk(1,0,0, 0,1,0,0, 1,82,1,0,0,1), "post_last");
        apply(mk(1,0,0, 0,1,0,0, 0, 0,0,1,0,1), "post_count");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
